// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared constants, state type and slot helpers for the vertex fetch stage
package gpu_pkg;

    localparam int FETCH_WORDS    = 10;
    localparam int COLOR_WORD_IDX = 9;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_BUSY
    } fetch_state_t;

    // Word k of a triangle lands in vertex k/3, coordinate k%3.
    function automatic logic [1:0] word_row(input logic [3:0] idx);
        return 2'(idx / 4'd3);
    endfunction

    function automatic logic [1:0] word_col(input logic [3:0] idx);
        return 2'(idx % 4'd3);
    endfunction

endpackage

// File: rtl/vertex_fetch_req.sv
// rtl/vertex_fetch_req.sv - read request generator: word index, address mux, outstanding window
module vertex_fetch_req
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int COORD_WIDTH     = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  busy,
    input  logic                  rsp,
    input  logic [ADDR_WIDTH-1:0] vertex_addr,
    input  logic [ADDR_WIDTH-1:0] color_addr,
    input  logic                  mem_waitrequest,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address
);

    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int STEP = COORD_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] vertex_base;
    logic [ADDR_WIDTH-1:0] color_base;
    logic [3:0]            req_idx;
    logic [3:0]            req_idx_next;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         outstanding_next;
    logic                  accept;

    always_comb begin
        accept           = mem_read && !mem_waitrequest;
        req_idx_next     = req_idx + {3'b000, accept};
        outstanding_next = outstanding + OW'(accept) - OW'(rsp);
    end

    // Request is decided from next-state values so a held request never drops mid-wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vertex_base <= '0;
            color_base  <= '0;
            req_idx     <= '0;
            outstanding <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
        end else if (start) begin
            vertex_base <= vertex_addr;
            color_base  <= color_addr;
            req_idx     <= '0;
            outstanding <= '0;
            mem_read    <= 1'b0;
        end else if (busy) begin
            req_idx     <= req_idx_next;
            outstanding <= outstanding_next;
            mem_read    <= (req_idx_next < 4'(FETCH_WORDS)) &&
                           (outstanding_next < OW'(MAX_OUTSTANDING));
            if (req_idx_next == 4'(COLOR_WORD_IDX))
                mem_address <= color_base;
            else if (req_idx_next < 4'(COLOR_WORD_IDX))
                mem_address <= vertex_base + ADDR_WIDTH'(req_idx_next) * ADDR_WIDTH'(STEP);
        end else begin
            mem_read <= 1'b0;
        end
    end

endmodule

// File: rtl/vertex_fetch.sv
// rtl/vertex_fetch.sv - triangle fetch stage (9 coords + color); VERTEX_FETCH_STATS_EN adds fetch_cycles
module vertex_fetch
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int COORD_WIDTH     = 16,
    parameter int COLOR_WIDTH     = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  fetch_start,
    input  logic [ADDR_WIDTH-1:0]                 curr_addr_vertex,
    input  logic [ADDR_WIDTH-1:0]                 curr_addr_color,
    output logic [2:0][2:0][COORD_WIDTH-1:0]      fetch_vertexes,
    output logic [COLOR_WIDTH-1:0]                fetch_color,
    output logic                                  fetch_eoc,
`ifdef VERTEX_FETCH_STATS_EN
    output logic [15:0]                           fetch_cycles,
`endif
    output logic                                  mem_read,
    output logic [ADDR_WIDTH-1:0]                 mem_address,
    input  logic                                  mem_waitrequest,
    input  logic [COORD_WIDTH-1:0]                mem_readdata,
    input  logic                                  mem_readdatavalid
);

    if (COLOR_WIDTH != COORD_WIDTH) begin : g_width_check
        $error("vertex_fetch: COLOR_WIDTH must equal COORD_WIDTH");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_window_check
        $error("vertex_fetch: MAX_OUTSTANDING must be 1..15");
    end

    fetch_state_t state;
    logic [3:0]   rsp_idx;
    logic         busy;
    logic         start_ok;
    logic         rsp;
    logic         last_rsp;

    assign busy     = (state == FETCH_BUSY);
    assign start_ok = fetch_start && (state == FETCH_IDLE);
    assign rsp      = busy && mem_readdatavalid;
    assign last_rsp = rsp && (rsp_idx == 4'(COLOR_WORD_IDX));

    vertex_fetch_req #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .COORD_WIDTH     (COORD_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_req (
        .clk             (clk),
        .rst             (reset),
        .start           (start_ok),
        .busy            (busy),
        .rsp             (rsp),
        .vertex_addr     (curr_addr_vertex),
        .color_addr      (curr_addr_color),
        .mem_waitrequest (mem_waitrequest),
        .mem_read        (mem_read),
        .mem_address     (mem_address)
    );

    // Responses return in order, so rsp_idx alone selects the destination slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH_IDLE;
            rsp_idx        <= '0;
            fetch_vertexes <= '0;
            fetch_color    <= '0;
            fetch_eoc      <= 1'b1;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (fetch_start) begin
                        state     <= FETCH_BUSY;
                        rsp_idx   <= '0;
                        fetch_eoc <= 1'b0;
                    end
                end
                FETCH_BUSY: begin
                    if (mem_readdatavalid) begin
                        if (rsp_idx == 4'(COLOR_WORD_IDX))
                            fetch_color <= mem_readdata;
                        else
                            fetch_vertexes[word_row(rsp_idx)][word_col(rsp_idx)] <= mem_readdata;
                        rsp_idx <= rsp_idx + 4'd1;
                        if (last_rsp) begin
                            state     <= FETCH_IDLE;
                            fetch_eoc <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef VERTEX_FETCH_STATS_EN
    // The completing cycle is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_cycles <= '0;
        else if (start_ok)
            fetch_cycles <= '0;
        else if (busy && !last_rsp && fetch_cycles != 16'hFFFF)
            fetch_cycles <= fetch_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vertex_fetch.sv
// tb/tb_vertex_fetch.sv - randomized scoreboard bench for vertex_fetch with a behavioural memory
module tb_vertex_fetch;

    localparam int AW   = 32;
    localparam int CW   = 16;
    localparam int MAXO = 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       fetch_start = 1'b0;
    logic [AW-1:0]              curr_addr_vertex = '0;
    logic [AW-1:0]              curr_addr_color = '0;
    logic [2:0][2:0][CW-1:0]    fetch_vertexes;
    logic [CW-1:0]              fetch_color;
    logic                       fetch_eoc;
`ifdef VERTEX_FETCH_STATS_EN
    logic [15:0]                fetch_cycles;
`endif
    logic                       mem_read;
    logic [AW-1:0]              mem_address;
    logic                       mem_waitrequest = 1'b0;
    logic [CW-1:0]              mem_readdata = '0;
    logic                       mem_readdatavalid = 1'b0;

    always #5 clk = ~clk;

    vertex_fetch #(
        .ADDR_WIDTH      (AW),
        .COORD_WIDTH     (CW),
        .COLOR_WIDTH     (CW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk               (clk),
        .reset             (rst),
        .fetch_start       (fetch_start),
        .curr_addr_vertex  (curr_addr_vertex),
        .curr_addr_color   (curr_addr_color),
        .fetch_vertexes    (fetch_vertexes),
        .fetch_color       (fetch_color),
        .fetch_eoc         (fetch_eoc),
`ifdef VERTEX_FETCH_STATS_EN
        .fetch_cycles      (fetch_cycles),
`endif
        .mem_read          (mem_read),
        .mem_address       (mem_address),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    typedef struct packed {
        logic [31:0] due;
        logic [15:0] data;
    } rsp_t;

    typedef struct packed {
        logic [143:0] v;
        logic [15:0]  c;
    } res_t;

    logic [31:0] exp_addr[$];
    res_t        exp_res[$];
    rsp_t        pend[$];

    int checks    = 0;
    int errors    = 0;
    int wait_pct  = 0;
    int lat_min   = 1;
    int lat_max   = 1;
    int n_accepts = 0;
    int cyc       = 0;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: word at address a holds a[15:0]; in-order responses with random latency.
    initial begin : memory
        rsp_t        p;
        logic [31:0] last_due;
        logic        held;
        logic [31:0] held_addr;
        int          lat;
        last_due  = '0;
        held      = 1'b0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_readdatavalid = 1'b0;
            if (!rst && pend.size() > 0 && pend[0].due <= 32'(cyc)) begin
                p = pend.pop_front();
                mem_readdatavalid = 1'b1;
                mem_readdata      = p.data;
            end
            if (held && !rst) begin
                check("hold_read", 144'(mem_read), 144'(1'b1));
                check("hold_addr", 144'(mem_address), 144'(held_addr));
            end
            mem_waitrequest = ($urandom_range(99) < 32'(wait_pct));
            if (!rst && mem_read && !mem_waitrequest) begin
                n_accepts++;
                lat = int'($urandom_range(32'(lat_max), 32'(lat_min)));
                if (32'(cyc + lat) > last_due) p.due = 32'(cyc + lat);
                else                           p.due = last_due + 32'd1;
                p.data   = mem_address[15:0];
                last_due = p.due;
                pend.push_back(p);
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got %0h expected none", mem_address);
                end else begin
                    check("req_addr", 144'(mem_address), 144'(exp_addr.pop_front()));
                end
                check("outstanding_le_max", 144'(pend.size() <= MAXO), 144'(1'b1));
            end
            held      = !rst && mem_read && mem_waitrequest;
            held_addr = mem_address;
        end
    end

    initial begin : result_mon
        logic prev_eoc;
        res_t r;
        prev_eoc = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && fetch_eoc && !prev_eoc) begin
                if (exp_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    r = exp_res.pop_front();
                    check("vertexes", 144'(fetch_vertexes), r.v);
                    check("color", 144'(fetch_color), 144'(r.c));
                end
            end
            prev_eoc = fetch_eoc;
        end
    end

    task automatic start_fetch(input logic [31:0] vb, input logic [31:0] cb);
        res_t r;
        r = '0;
        for (int k = 0; k < 9; k++) begin
            logic [31:0] a;
            a = vb + 32'(2 * k);
            exp_addr.push_back(a);
            r.v[k*16 +: 16] = a[15:0];
        end
        exp_addr.push_back(cb);
        r.c = cb[15:0];
        exp_res.push_back(r);
        @(negedge clk);
        curr_addr_vertex = vb;
        curr_addr_color  = cb;
        fetch_start      = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
    endtask

    task automatic wait_eoc(output int k);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            #1;
        end while (!fetch_eoc && k < 3000);
        if (!fetch_eoc) begin
            checks++;
            errors++;
            $display("FAIL timeout_eoc: got eoc=0 expected eoc=1 within 3000 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        int          k;
        int          a0;
        logic [31:0] vb;
        logic [31:0] cb;

        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_eoc", 144'(fetch_eoc), 144'(1'b1));
        check("reset_vertexes", 144'(fetch_vertexes), 144'(0));
        check("reset_color", 144'(fetch_color), 144'(0));
        check("reset_mem_read", 144'(mem_read), 144'(1'b0));
        check("reset_mem_address", 144'(mem_address), 144'(0));
        check("reset_no_requests", 144'(n_accepts), 144'(0));
`ifdef VERTEX_FETCH_STATS_EN
        check("reset_cycles", 144'(fetch_cycles), 144'(0));
`endif

        wait_pct = 0; lat_min = 1; lat_max = 1;
        start_fetch(32'h1000, 32'h2000);
        wait_eoc(k);
        check("eoc_latency", 144'(k), 144'(12));
        check("v12_directed", 144'(fetch_vertexes[1][2]), 144'(16'h100A));
        check("color_directed", 144'(fetch_color), 144'(16'h2000));
`ifdef VERTEX_FETCH_STATS_EN
        check("fetch_cycles", 144'(fetch_cycles), 144'(11));
`endif

        wait_pct = 50; lat_min = 1; lat_max = 6;
        start_fetch(32'h1000, 32'h2000);
        wait_eoc(k);
        check("v12_random_wait", 144'(fetch_vertexes[1][2]), 144'(16'h100A));

        wait_pct = 0; lat_min = 1; lat_max = 3;
        a0 = n_accepts;
        start_fetch(32'h3000, 32'h4000);
        repeat (2) @(negedge clk);
        curr_addr_vertex = 32'h5000;
        curr_addr_color  = 32'h6000;
        fetch_start      = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        wait_eoc(k);
        check("restart_req_count", 144'(n_accepts - a0), 144'(10));

        wait_pct = 30; lat_min = 1; lat_max = 4;
        a0 = n_accepts;
        start_fetch(32'hFFFF_FFFC, 32'h0000_0100);
        wait_eoc(k);
        check("wrap_req_count", 144'(n_accepts - a0), 144'(10));
        check("wrap_v10", 144'(fetch_vertexes[1][0]), 144'(16'h0002));

        wait_pct = 0; lat_min = 6; lat_max = 6;
        a0 = n_accepts;
        start_fetch(32'h7000, 32'h8000);
        k = 0;
        while (n_accepts < a0 + 4 && k < 500) begin
            @(posedge clk);
            k++;
        end
        check("reset_mid_accepts", 144'(n_accepts - a0), 144'(4));
        #3 rst = 1'b1;
        exp_addr.delete();
        exp_res.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        k = 0;
        while (pend.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("late_rsp_drained", 144'(pend.size()), 144'(0));
        check("post_reset_vertexes", 144'(fetch_vertexes), 144'(0));
        check("post_reset_color", 144'(fetch_color), 144'(0));
        check("post_reset_eoc", 144'(fetch_eoc), 144'(1'b1));
        check("post_reset_mem_read", 144'(mem_read), 144'(1'b0));

        for (int i = 0; i < 5; i++) begin
            wait_pct = int'($urandom_range(60));
            lat_min  = 1;
            lat_max  = int'($urandom_range(6, 1));
            vb = $urandom & 32'hFFFF_FFFE;
            cb = $urandom & 32'hFFFF_FFFE;
            start_fetch(vb, cb);
            wait_eoc(k);
        end

        check("addr_queue_empty", 144'(exp_addr.size()), 144'(0));
        check("result_queue_empty", 144'(exp_res.size()), 144'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vertex_fetch.md
Name: vertex_fetch

Overview:
Data-fetch stage directly upstream of the triangle pipeline controller. On each fetch_start pulse it latches the current vertex and color byte addresses. It then reads one triangle from memory over a pipelined read master: nine coordinate words followed by one color word. It presents the results on fetch_vertexes/fetch_color, raising fetch_eoc when complete. Outputs are held stable until the next fetch_start.

Parameters:
ADDR_WIDTH, 32, byte-address width of memory and address inputs
COORD_WIDTH, 16, coordinate width; also the memory data width
COLOR_WIDTH, 16, color width; must equal COORD_WIDTH (elaboration assertion)
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered reads (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
fetch_start  in  1  one-cycle pulse: fetch a triangle
curr_addr_vertex  in  ADDR_WIDTH  byte address of coordinate word 0
curr_addr_color  in  ADDR_WIDTH  byte address of color word
fetch_vertexes  out  COORD_WIDTH x [3][3]  [v][c] = coordinate c of vertex v
fetch_color  out  COLOR_WIDTH  triangle color
fetch_eoc  out  1  level: idle with valid or reset data
mem_read  out  1  read request
mem_address  out  ADDR_WIDTH  byte address of request
mem_waitrequest  in  1  request not accepted this cycle
mem_readdata  in  COORD_WIDTH  response data
mem_readdatavalid  in  1  response valid; responses return in order

Behaviour:
- Reset values:
  - fetch_vertexes and fetch_color: 0.
  - fetch_eoc: 1. Downstream can start immediately.
  - mem_read and mem_address: 0.
  - State: IDLE. All counters: 0.
- States:
  - IDLE -> BUSY on fetch_start. Latch both addresses; clear req_idx and rsp_idx; fetch_eoc drops to 0 the next cycle.
  - BUSY -> IDLE the cycle after the 10th response is captured. fetch_eoc = 1 in that same registered update.
- Request order and addresses (req_idx 0..9):
  - Words 0..8: mem_address = vertex_base + 2*req_idx (step = COORD_WIDTH/8 bytes). Word k maps to fetch_vertexes[k/3][k%3].
  - Word 9: mem_address = color_base.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Request handshake:
  - mem_read and mem_address are registered.
  - mem_read is asserted while req_idx < 10 and outstanding < MAX_OUTSTANDING.
  - A request is accepted when mem_read && !mem_waitrequest. On acceptance req_idx increments.
  - Request signals hold while mem_waitrequest is high.
- Outstanding count:
  - Increments on acceptance and decrements on response.
  - Simultaneous accept and response leaves it unchanged.
  - It never exceeds MAX_OUTSTANDING.
- Responses: each mem_readdatavalid writes mem_readdata into the slot given by rsp_idx, then increments rsp_idx.
  - Outputs update in place while fetch_eoc = 0. Consumers sample only while fetch_eoc = 1.
- Latency: with waitrequest = 0, a 1-cycle read latency and MAX_OUTSTANDING >= 2:
  - fetch_start sampled at edge t.
  - Requests at t+1..t+10; responses at t+2..t+11.
  - fetch_eoc = 1 from t+12.
- Boundary conditions:
  - fetch_start while BUSY: ignored. No restart, no corruption.
  - fetch_start in the same cycle as the final response: ignored, because state is still BUSY.
  - mem_readdatavalid while IDLE: ignored.
  - Reset mid-fetch: immediate return to reset values. Outstanding responses arriving after reset deassertion fall in IDLE and are discarded.

Optional Feature:
- Macro: VERTEX_FETCH_STATS_EN.
- When defined, add output fetch_cycles [15:0]:
  - Cleared on the fetch_start acceptance.
  - Incremented every BUSY cycle, saturating at 16'hFFFF.
  - Holds its value in IDLE; reset value 0.
- When undefined: no port and no counter logic.

Decomposition:
- Package gpu_pkg holds:
  - FETCH_WORDS = 10 and COLOR_WORD_IDX = 9.
  - The enum fetch_state_t {FETCH_IDLE, FETCH_BUSY}.
- One sub-module, vertex_fetch_req: request generator (req_idx, address mux, outstanding counter, mem_read/mem_address).
- Response capture and FSM stay in the top module.

Test Plan:
- Reset then idle → fetch_eoc = 1, all outputs 0, mem_read = 0 with no requests.
- vertex = 0x1000, color = 0x2000, zero waitrequest, latency 1, memory word = address[15:0] → requests 0x1000..0x1010 step 2 then 0x2000; fetch_vertexes[1][2] = 0x100A; fetch_color = 0x2000; fetch_eoc rises exactly 12 cycles after start.
- Random waitrequest (50%) and latency 1..6, MAX_OUTSTANDING = 2 → outstanding never > 2, address held during wait, final data identical to the previous case.
- Second fetch_start 3 cycles into BUSY → ignored; exactly 10 requests issued; data matches the first addresses.
- vertex = 0xFFFF_FFFC → addresses wrap: 0xFFFF_FFFC, 0xFFFF_FFFE, 0x0000_0000, ..., 0x0000_000C.
- Reset asserted after 4 requests, released, 2 late responses → discarded; outputs 0; fetch_eoc = 1; a subsequent fetch completes correctly. With VERTEX_FETCH_STATS_EN defined: fetch_cycles = 11 for the second scenario.
